// File: rtl/mem_port_arbiter.sv
// Shares one single-ported req/ack memory between instruction fetch and data load/store:
// data wins contested arbitrations, fetch is forced through after STARVE_LIMIT losses.
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 64
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    output logic        o_if_gnt,
    output logic        o_if_rvalid,
    output logic [31:0] o_if_rdata,
    input  logic        i_d_req,
    input  logic        i_d_we,
    input  logic [31:0] i_d_addr,
    input  logic [31:0] i_d_wdata,
    input  logic [3:0]  i_d_be,
    output logic        o_d_gnt,
    output logic        o_d_rvalid,
    output logic [31:0] o_d_rdata,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_be,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata,
    output logic        o_busy,
    output logic        o_timeout_err
);
    // state   | meaning
    // IDLE    | port free, arbitrate on every edge
    // BUSY_I  | fetch owns the memory port, waiting for ack or watchdog
    // BUSY_D  | data load/store owns the memory port, waiting for ack or watchdog
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2
    } state_t;

    localparam logic [3:0] LP_STARVE_MAX = 4'(STARVE_LIMIT);
    localparam bit         LP_WD_EN      = (TIMEOUT != 0);
    localparam logic [7:0] LP_WD_LAST    = LP_WD_EN ? 8'(TIMEOUT - 1) : 8'd0;

    state_t     r_state;
    logic [3:0] r_starve_cnt;
    logic [7:0] r_wd_cnt;
    logic       w_d_wins;
    logic       w_if_wins;
    logic       w_wd_expire;
    logic       w_done;

    always_comb begin
        w_d_wins    = i_d_req && !(i_if_req && (r_starve_cnt == LP_STARVE_MAX));
        w_if_wins   = i_if_req && !w_d_wins;
        w_wd_expire = LP_WD_EN && (r_wd_cnt == LP_WD_LAST);
        w_done      = i_mem_ack || w_wd_expire;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state       <= ST_IDLE;
            r_starve_cnt  <= 4'd0;
            r_wd_cnt      <= 8'd0;
            o_if_gnt      <= 1'b0;
            o_if_rvalid   <= 1'b0;
            o_if_rdata    <= 32'h0;
            o_d_gnt       <= 1'b0;
            o_d_rvalid    <= 1'b0;
            o_d_rdata     <= 32'h0;
            o_mem_req     <= 1'b0;
            o_mem_we      <= 1'b0;
            o_mem_addr    <= 32'h0;
            o_mem_wdata   <= 32'h0;
            o_mem_be      <= 4'h0;
            o_busy        <= 1'b0;
            o_timeout_err <= 1'b0;
        end else begin
            o_if_gnt    <= 1'b0;
            o_d_gnt     <= 1'b0;
            o_if_rvalid <= 1'b0;
            o_d_rvalid  <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_d_wins) begin
                        r_state     <= ST_BUSY_D;
                        o_d_gnt     <= 1'b1;
                        o_mem_req   <= 1'b1;
                        o_busy      <= 1'b1;
                        o_mem_we    <= i_d_we;
                        o_mem_addr  <= i_d_addr;
                        o_mem_wdata <= i_d_wdata;
                        o_mem_be    <= i_d_we ? i_d_be : 4'hF;
                        // contested loss; the counter cannot be at its limit here
                        if (i_if_req) begin
                            r_starve_cnt <= r_starve_cnt + 4'd1;
                        end
                    end else if (w_if_wins) begin
                        r_state      <= ST_BUSY_I;
                        o_if_gnt     <= 1'b1;
                        o_mem_req    <= 1'b1;
                        o_busy       <= 1'b1;
                        o_mem_we     <= 1'b0;
                        o_mem_addr   <= i_if_addr;
                        o_mem_wdata  <= 32'h0;
                        o_mem_be     <= 4'hF;
                        r_starve_cnt <= 4'd0;
                    end
                end
                ST_BUSY_I, ST_BUSY_D: begin
                    if (w_done) begin
                        r_state   <= ST_IDLE;
                        o_mem_req <= 1'b0;
                        o_busy    <= 1'b0;
                        r_wd_cnt  <= 8'd0;
                        if (!i_mem_ack) begin
                            o_timeout_err <= 1'b1;
                        end
                        // an aborted read returns zero data to its owner
                        if (r_state == ST_BUSY_I) begin
                            o_if_rvalid <= 1'b1;
                            o_if_rdata  <= i_mem_ack ? i_mem_rdata : 32'h0;
                        end else begin
                            o_d_rvalid <= 1'b1;
                            if (!o_mem_we) begin
                                o_d_rdata <= i_mem_ack ? i_mem_rdata : 32'h0;
                            end
                        end
                    end else begin
                        r_wd_cnt <= r_wd_cnt + 8'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: random fetch/data traffic against a behavioural
// memory, plus directed cases for latency, starvation, watchdog and reset.
module tb_mem_port_arbiter;
    localparam int STARVE_LIMIT = 4;
    localparam int TIMEOUT      = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, if_gnt, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_be;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        busy, timeout_err;
    logic [139:0] all_outs;

    always #5 clk = ~clk;

    mem_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_if_req(if_req), .i_if_addr(if_addr), .o_if_gnt(if_gnt),
        .o_if_rvalid(if_rvalid), .o_if_rdata(if_rdata),
        .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
        .i_d_be(d_be), .o_d_gnt(d_gnt), .o_d_rvalid(d_rvalid), .o_d_rdata(d_rdata),
        .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .o_mem_be(mem_be), .i_mem_ack(mem_ack),
        .i_mem_rdata(mem_rdata), .o_busy(busy), .o_timeout_err(timeout_err)
    );

    assign all_outs = {if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, mem_req,
                       mem_we, mem_addr, mem_wdata, mem_be, busy, timeout_err};

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int len;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] if_q[$];
    logic [31:0] d_q[$];
    logic [31:0] ref_mem[logic [31:0]];
    logic [31:0] env_mem[logic [31:0]];
    logic [31:0] last_d = 32'h0;
    byte unsigned grant_log[$];
    bit          log_grants = 1'b0;
    bit          exp_busy = 1'b0;
    logic [68:0] exp_mem = '0;
    int          if_gnt_cyc = -1;
    int          d_rv_cyc = -1;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] env_rd(input logic [31:0] a);
        return env_mem.exists(a) ? env_mem[a] : init_word(a);
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] v);
        ref_mem[a] = v;
        env_mem[a] = v;
    endtask

    // behavioural memory: random ack latency, writes land when ack is raised
    bit          ack_en = 1'b1;
    int unsigned lat_min = 0, lat_max = 0, resp_cnt = 0;
    bit          resp_active = 1'b0;
    initial begin
        logic [31:0] w;
        mem_ack = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            #1;
            if (mem_ack) begin
                mem_ack = 1'b0;
                resp_active = 1'b0;
            end else if (resp_active && !mem_req) begin
                resp_active = 1'b0;
            end else if (mem_req && !resp_active) begin
                resp_active = 1'b1;
                resp_cnt = $urandom_range(lat_max, lat_min);
            end
            if (resp_active && !mem_ack && ack_en) begin
                if (resp_cnt == 0) begin
                    mem_ack = 1'b1;
                    mem_rdata = env_rd(mem_addr);
                    if (mem_we) begin
                        w = env_rd(mem_addr);
                        for (int b = 0; b < 4; b++)
                            if (mem_be[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
                        env_mem[mem_addr] = w;
                    end
                end else begin
                    resp_cnt--;
                end
            end
        end
    end

    // monitor: grants latch the expected memory command, rvalids pop the scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (if_gnt || d_gnt) begin
                check("gnt_onehot", 160'(if_gnt & d_gnt), 160'(0));
                exp_busy = 1'b1;
                if (if_gnt) begin
                    exp_mem = {1'b0, 4'hF, if_addr, 32'h0};
                    if (log_grants) grant_log.push_back("I");
                end else begin
                    exp_mem = {d_we, (d_we ? d_be : 4'hF), d_addr, d_wdata};
                    if (log_grants) grant_log.push_back("D");
                end
                if (if_gnt) if_gnt_cyc = cyc;
            end else if (if_rvalid || d_rvalid) begin
                exp_busy = 1'b0;
            end
            check("busy_memreq", 160'({busy, mem_req}), 160'({exp_busy, exp_busy}));
            if (exp_busy)
                check("mem_cmd", 160'({mem_req, mem_we, mem_be, mem_addr, mem_wdata}),
                      160'({1'b1, exp_mem}));
            if (if_rvalid) begin
                if (if_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL if_rvalid_extra: got rvalid with data %0h, expected none", if_rdata);
                end else begin
                    check("if_rdata", 160'(if_rdata), 160'(if_q.pop_front()));
                end
            end
            if (d_rvalid) begin
                d_rv_cyc = cyc;
                if (d_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL d_rvalid_extra: got rvalid with data %0h, expected none", d_rdata);
                end else begin
                    check("d_rdata", 160'(d_rdata), 160'(d_q.pop_front()));
                end
            end
        end
    end

    task automatic wait_gnt(input bit is_d);
        bit seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            seen = is_d ? d_gnt : if_gnt;
        end
        check(is_d ? "d_gnt_wait" : "if_gnt_wait", 160'(seen), 160'(1));
        #1;
    endtask

    task automatic fetch_one(input logic [31:0] addr);
        if_req = 1'b1;
        if_addr = addr;
        if_q.push_back(ref_rd(addr));
        wait_gnt(1'b0);
        if_req = 1'b0;
    endtask

    task automatic data_one(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] be, input bit aborts);
        logic [31:0] m;
        d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; d_be = be;
        if (we) begin
            m = ref_rd(addr);
            for (int b = 0; b < 4; b++) if (be[b]) m[8*b +: 8] = wdata[8*b +: 8];
            ref_mem[addr] = m;
        end else begin
            last_d = aborts ? 32'h0 : ref_rd(addr);
        end
        d_q.push_back(last_d);
        wait_gnt(1'b1);
        d_req = 1'b0;
    endtask

    task automatic fetch_stream(input int n, input int unsigned gap_max);
        int unsigned gap;
        for (int i = 0; i < n; i++) begin
            gap = $urandom_range(gap_max, 0);
            repeat (gap) begin @(negedge clk); #1; end
            fetch_one({22'h0, 8'($urandom_range(255, 0)), 2'b00});
        end
    endtask

    task automatic data_stream(input int n, input int unsigned gap_max);
        int unsigned gap;
        for (int i = 0; i < n; i++) begin
            gap = $urandom_range(gap_max, 0);
            repeat (gap) begin @(negedge clk); #1; end
            data_one(1'($urandom_range(1, 0)), 32'h2000 + {24'h0, 6'($urandom_range(63, 0)), 2'b00},
                     $urandom, 4'($urandom_range(15, 0)), 1'b0);
        end
    endtask

    task automatic measure_req(output int n);
        bit started = 1'b0;
        n = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (mem_req) begin
                started = 1'b1;
                n++;
            end else if (started) begin
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; if_req = 1'b0; d_req = 1'b0;
        if_q.delete(); d_q.delete();
        last_d = 32'h0; exp_busy = 1'b0;
        @(negedge clk);
        check("reset_outputs", 160'(all_outs), 160'(0));
        #1 rst_n = 1'b1;
    endtask

    task automatic drain();
        for (int k = 0; k < 300 && (if_q.size() != 0 || d_q.size() != 0 || busy); k++)
            @(negedge clk);
        check("drain_if_q", 160'(if_q.size()), 160'(0));
        check("drain_d_q", 160'(d_q.size()), 160'(0));
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "global timeout");
    end

    initial begin
        logic [31:0] keep, merged;
        int losses;
        byte unsigned e;
        rst_n = 1'b0; if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
        repeat (2) @(negedge clk);
        #1;
        do_reset();

        // single fetch, two wait cycles
        preload(32'h100, 32'h0050_0093);
        lat_min = 2; lat_max = 2;
        fork fetch_one(32'h100); measure_req(len); join
        check("t1_req_cycles", 160'(len), 160'(3));
        check("t1_rvalid_data", 160'({if_rvalid, if_rdata, busy}), 160'({1'b1, 32'h0050_0093, 1'b0}));
        #1;

        // store leaves d_rdata untouched, then reads back merged bytes
        lat_min = 0; lat_max = 0;
        data_one(1'b0, 32'h2010, 32'h0, 4'h0, 1'b0);
        drain();
        keep = last_d;
        fork data_one(1'b1, 32'h2000, 32'hCAFE_BABE, 4'b0011, 1'b0); measure_req(len); join
        check("t2_store_cycles", 160'(len), 160'(1));
        check("t2_store_rdata_kept", 160'({d_rvalid, d_rdata}), 160'({1'b1, keep}));
        #1;
        merged = init_word(32'h2000);
        merged[15:0] = 16'hBABE;
        fork data_one(1'b0, 32'h2000, 32'h0, 4'h0, 1'b0); measure_req(len); join
        check("t2_readback", 160'(d_rdata), 160'(merged));
        #1;

        // both requesters held, zero-wait ack
        do_reset();
        grant_log.delete();
        log_grants = 1'b1;
        fork fetch_stream(3, 0); data_stream(10, 0); join
        drain();
        log_grants = 1'b0;
        losses = 0;
        for (int k = 0; k < 10; k++) begin
            if (losses == STARVE_LIMIT) begin e = "I"; losses = 0; end
            else begin e = "D"; losses++; end
            check($sformatf("starve_seq_%0d", k), 160'((k < grant_log.size()) ? grant_log[k] : 8'h0), 160'(e));
        end

        // ack on the last watchdog cycle wins, then a silent memory trips the watchdog
        do_reset();
        lat_min = 0; lat_max = 0;
        data_one(1'b0, 32'h2024, 32'h0, 4'h0, 1'b0);
        drain();
        lat_min = TIMEOUT - 1; lat_max = TIMEOUT - 1;
        fork data_one(1'b0, 32'h2028, 32'h0, 4'h0, 1'b0); measure_req(len); join
        check("t4_late_ack_cycles", 160'(len), 160'(TIMEOUT));
        check("t4_late_ack_no_err", 160'(timeout_err), 160'(0));
        #1;
        ack_en = 1'b0;
        fork data_one(1'b0, 32'h2020, 32'h0, 4'h0, 1'b1); measure_req(len); join
        check("t4_timeout_cycles", 160'(len), 160'(TIMEOUT));
        check("t4_timeout_rvalid", 160'({d_rvalid, d_rdata, timeout_err}), 160'({1'b1, 32'h0, 1'b1}));
        repeat (5) @(negedge clk);
        check("t4_err_sticky", 160'(timeout_err), 160'(1));
        #1;
        ack_en = 1'b1;
        do_reset();

        // reset in the middle of a fetch drops it
        lat_min = 5; lat_max = 5;
        fetch_one(32'h140);
        @(negedge clk);
        #1;
        do_reset();
        lat_min = 1; lat_max = 1;
        fork fetch_one(32'h144); measure_req(len); join
        check("t5_after_reset", 160'({if_rvalid, if_rdata}), 160'({1'b1, ref_rd(32'h144)}));
        #1;

        // fetch raised during the load's ack cycle is granted right after d_rvalid
        preload(32'h2040, 32'h1234_5678);
        fork
            data_one(1'b0, 32'h2040, 32'h0, 4'h0, 1'b0);
            begin
                for (int k = 0; k < 50; k++) begin
                    @(negedge clk);
                    #2;
                    if (mem_ack) break;
                end
                fetch_one(32'h180);
            end
        join
        drain();
        check("t6_gnt_after_rvalid", 160'(if_gnt_cyc), 160'(d_rv_cyc + 1));

        // random mixed traffic
        do_reset();
        lat_min = 0; lat_max = TIMEOUT - 1;
        fork fetch_stream(40, 3); data_stream(40, 3); join
        drain();
        check("random_no_timeout", 160'(timeout_err), 160'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the pipeline's instruction-fetch requester and its data-memory (load/store) requester.
- Runs a fixed-priority arbitration: data beats fetch, with a starvation guard for fetch.
- Sequences each transaction over a variable-latency req/ack memory interface, and provides a watchdog timeout.
- Sits between the pipeline core (IF and MEM stages) and the memory model/controller.

Parameters:
STARVE_LIMIT, 4, consecutive contested arbitrations fetch may lose before it is forced to win (1..15)
TIMEOUT, 64, max cycles in a busy state without mem_ack before abort; 0 disables the watchdog (0..255)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, synchronous, active-low
if_req  in  1  fetch request; held with if_addr until if_gnt seen
if_addr  in  32  fetch address
if_gnt  out  1  one-cycle pulse: fetch request accepted
if_rvalid  out  1  one-cycle pulse: if_rdata valid
if_rdata  out  32  fetched instruction
d_req  in  1  data request; held with d_we/d_addr/d_wdata/d_be until d_gnt seen
d_we  in  1  1=store, 0=load
d_addr  in  32  data address
d_wdata  in  32  store data
d_be  in  4  store byte enables
d_gnt  out  1  one-cycle pulse: data request accepted
d_rvalid  out  1  one-cycle pulse: load data valid, or store complete
d_rdata  out  32  load data
mem_req  out  1  memory request, held until ack
mem_we  out  1  memory write enable
mem_addr  out  32  memory address
mem_wdata  out  32  memory write data
mem_be  out  4  memory byte enables (4'hF for fetch and loads)
mem_ack  in  1  memory completes the transaction on the edge where it is sampled high
mem_rdata  in  32  read data, valid with mem_ack
busy  out  1  state != IDLE
timeout_err  out  1  sticky watchdog error flag

Behaviour:
- Clock and reset: one clock, clk. rst_n is synchronous, active-low; it is sampled only on the rising edge of clk.
- Registered outputs: all outputs are registered.
- Reset values: every output is 0. State is IDLE, both counters are 0, timeout_err is 0.
- Reset mid-transaction: the transaction is dropped. No rvalid is issued, and mem_req is 0 the cycle after the reset edge.
- FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE, arbitration on each edge:
  - d_req alone -> BUSY_D.
  - if_req alone -> BUSY_I.
  - Both high -> BUSY_D, unless starve_cnt == STARVE_LIMIT, in which case -> BUSY_I.
  - Neither high -> stay in IDLE.
- Entering a BUSY state on edge t:
  - mem_req=1 from cycle t.
  - mem_we, mem_addr, mem_wdata and mem_be are latched from the winner. Fetch drives we=0, be=4'hF, wdata=0. A data load drives be=4'hF.
  - The winner's gnt=1 for cycle t only.
- starve_cnt (4-bit): increments by 1 when both requests are high and data wins. It clears whenever fetch is granted. It saturates at STARVE_LIMIT.
- BUSY_x:
  - New requests are ignored.
  - mem_* outputs are held stable.
  - wd_cnt increments each cycle.
- mem_ack sampled high in BUSY_x:
  - Next cycle: state IDLE, mem_req=0, x_rvalid=1 for one cycle.
  - BUSY_I: if_rdata <= mem_rdata.
  - BUSY_D load: d_rdata <= mem_rdata.
  - BUSY_D store: d_rdata is unchanged.
  - wd_cnt clears.
- Zero-wait latency: mem_ack may be high in the first cycle of mem_req. The minimum sequence is req edge -> gnt/mem_req cycle -> rvalid cycle (IDLE). Peak throughput is one transaction per 2 cycles.
- Watchdog: when TIMEOUT != 0 and wd_cnt reaches TIMEOUT-1 with no ack:
  - Next cycle: IDLE, mem_req=0, timeout_err=1 (stays 1 until reset).
  - The owner receives rvalid=1, with rdata forced to 32'h0 for reads.
  - An ack on that same edge takes precedence; no error is raised.
- rvalid on data outputs: if_rdata and d_rdata hold their values between rvalid pulses.
- Requester obligations: requests must stay high until gnt. A request that drops before gnt is never granted. After gnt, a requester may raise a new request, which is arbitrated on the first IDLE edge.

Test Plan:
- Reset then single fetch, if_addr=0x100, mem_ack after 2 wait cycles, mem_rdata=0x00500093 -> if_gnt pulse, mem_addr=0x100 with mem_be=F held for 3 cycles, then if_rvalid=1 with if_rdata=0x00500093, busy=0.
- Store d_addr=0x2000, d_wdata=0xCAFEBABE, d_be=4'b0011, zero-wait ack -> mem_we=1 with matching addr/data/be for 1 cycle, d_rvalid=1, d_rdata unchanged.
- if_req and d_req held continuously with zero-wait ack, STARVE_LIMIT=4 -> grant sequence D,D,D,D,I,D,D,D,D,I.
- TIMEOUT=8, d load issued and mem_ack never asserted -> mem_req=1 for exactly 8 cycles, then d_rvalid=1, d_rdata=0, timeout_err=1 persisting until rst_n=0.
- rst_n=0 for one edge during BUSY_I -> next cycle all outputs 0, no if_rvalid; a following fetch completes normally.
- Load returns mem_rdata=0x12345678 while if_req rises in the ack cycle -> d_rvalid=1 with d_rdata=0x12345678, then if_gnt on the next edge.
